parallel_out_mm: RTL and testbench

Parametrised memory-mapped parallel output port. It sits on the processor's data-memory bus next to RAM and generalises the single fixed-address display latch into NUM_CH independently addressed output registers. It adds a buffered stream channel with a valid/ready handshake toward a slow peripheral (display or LED driver), plus register readback and a status/overflow register.

---
 rtl/parallel_out_mm.sv | 124 ++++++++++++
 tb/tb_parallel_out_mm.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/parallel_out_mm.sv
// Memory-mapped parallel output port: NUM_CH direct output registers, a buffered
// valid/ready stream channel, register readback and a status/overflow register.
module parallel_out_mm #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned NUM_CH     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'hF8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     we_i,
    input  logic                     re_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     rd_valid_o,
    output logic [NUM_CH*DATA_W-1:0] ch_out_o,
    output logic [DATA_W-1:0]        strm_data_o,
    output logic                     strm_valid_o,
    input  logic                     strm_ready_i,
    output logic                     overflow_o
);

    localparam int unsigned IdxW = $clog2(FIFO_DEPTH);
    localparam int unsigned PtrW = IdxW + 1;

    logic [ADDR_W-1:0] offset;
    logic              hit_push, hit_stat;

    logic [DATA_W-1:0] ch_q [NUM_CH];
    logic [DATA_W-1:0] ch_d [NUM_CH];
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill;
    logic [DATA_W-1:0] head_q, head_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q;

    logic              full, empty, pop, push_req, push_ok;
    logic [IdxW-1:0]   wr_idx, rd_idx_d;
    logic [7:0]        status;

    // Addresses below BASE_ADDR wrap to large offsets and fall outside the map.
    assign offset   = addr_i - BASE_ADDR;
    assign hit_push = (offset == ADDR_W'(NUM_CH));
    assign hit_stat = (offset == ADDR_W'(NUM_CH + 1));

    assign full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {IdxW{1'b0}}});
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign fill     = wr_ptr_q - rd_ptr_q;
    assign status   = {ovf_q, full, empty, 5'(fill)};

    assign pop      = !empty && strm_ready_i;
    assign push_req = we_i && hit_push;
    assign push_ok  = push_req && (!full || pop);
    assign wr_idx   = wr_ptr_q[IdxW-1:0];
    assign rd_idx_d = rd_ptr_d[IdxW-1:0];

    always_comb begin
        wr_ptr_d  = wr_ptr_q + PtrW'(push_ok);
        rd_ptr_d  = rd_ptr_q + PtrW'(pop);
        ovf_d     = ovf_q;
        head_d    = head_q;
        ch_d      = ch_q;
        rd_data_d = rd_data_q;

        if (we_i && hit_stat) ovf_d = 1'b0;
        if (push_req && !push_ok) ovf_d = 1'b1;

        // Head register holds its last value once the FIFO drains.
        if (wr_ptr_d != rd_ptr_d) begin
            if (push_ok && (wr_idx == rd_idx_d)) head_d = wr_data_i;
            else                                 head_d = mem_q[rd_idx_d];
        end

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (we_i && (offset == ADDR_W'(i))) ch_d[i] = wr_data_i;
        end

        if (re_i) begin
            rd_data_d = '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (offset == ADDR_W'(i)) rd_data_d = ch_q[i];
            end
            if (hit_stat) rd_data_d = DATA_W'(status);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            head_q     <= '0;
            ovf_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            ch_q       <= ch_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            head_q     <= head_d;
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= re_i;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_idx] <= wr_data_i;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_out
        assign ch_out_o[g*DATA_W +: DATA_W] = ch_q[g];
    end

    assign rd_data_o    = rd_data_q;
    assign rd_valid_o   = rd_valid_q;
    assign strm_data_o  = head_q;
    assign strm_valid_o = !empty;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_parallel_out_mm.sv
// Bench for parallel_out_mm: register vector table plus stream scoreboard sequences.
module tb_parallel_out_mm;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr_i = '0;
    logic [7:0]  wr_data_i = '0;
    logic        we_i = 1'b0;
    logic        re_i = 1'b0;
    logic [7:0]  rd_data_o;
    logic        rd_valid_o;
    logic [31:0] ch_out_o;
    logic [7:0]  strm_data_o;
    logic        strm_valid_o;
    logic        strm_ready_i = 1'b0;
    logic        overflow_o;

    parallel_out_mm dut (
        .clk         (clk),
        .rst         (rst),
        .addr_i      (addr_i),
        .wr_data_i   (wr_data_i),
        .we_i        (we_i),
        .re_i        (re_i),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .ch_out_o    (ch_out_o),
        .strm_data_o (strm_data_o),
        .strm_valid_o(strm_valid_o),
        .strm_ready_i(strm_ready_i),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    logic [7:0]  q[$];
    logic        exp_ovf = 1'b0;
    logic        mon_en  = 1'b0;

    typedef struct {
        logic        is_wr;
        logic [7:0]  addr;
        logic [7:0]  data;
        logic [31:0] exp_ch;
        logic [7:0]  exp_rd;
        string       name;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr_i = a; wr_data_i = d; we_i = 1'b1;
        tick();
        we_i = 1'b0;
        if (a == 8'hFD) exp_ovf = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
        addr_i = a; re_i = 1'b1;
        tick();
        re_i = 1'b0;
        chk(nm, rd_data_o, exp);
        chk({nm, " rd_valid"}, rd_valid_o, 1);
        tick();
        chk({nm, " rd_valid drop"}, rd_valid_o, 0);
    endtask

    // Acceptance is decided from the model before the edge; the entry joins the
    // scoreboard after the edge so queue size tracks the DUT count at negedge.
    task automatic push(input logic [7:0] d);
        bit acc;
        acc = (q.size() < 4) || (strm_ready_i && q.size() > 0);
        addr_i = 8'hFC; wr_data_i = d; we_i = 1'b1;
        tick();
        we_i = 1'b0;
        if (acc) q.push_back(d);
        else     exp_ovf = 1'b1;
    endtask

    task automatic drain(input string nm);
        strm_ready_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (q.size() == 0) break;
        end
        chk({nm, " drained"}, q.size(), 0);
        strm_ready_i = 1'b0;
        chk({nm, " strm_valid low"}, strm_valid_o, 0);
    endtask

    // Stream monitor: the handshake seen at negedge completes at the next posedge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("strm_valid", strm_valid_o, (q.size() > 0));
            chk("overflow", overflow_o, exp_ovf);
            if (strm_valid_o && strm_ready_i && q.size() > 0) begin
                chk("strm_data", strm_data_o, q[0]);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        tbl[0]  = '{1'b1, 8'hF8, 8'hA5, 32'h000000A5, 8'h00, "wr ch0"};
        tbl[1]  = '{1'b1, 8'hFB, 8'h3C, 32'h3C0000A5, 8'h00, "wr ch3"};
        tbl[2]  = '{1'b0, 8'hFB, 8'h00, 32'h3C0000A5, 8'h3C, "rd ch3"};
        tbl[3]  = '{1'b0, 8'hF8, 8'h00, 32'h3C0000A5, 8'hA5, "rd ch0"};
        tbl[4]  = '{1'b0, 8'hF9, 8'h00, 32'h3C0000A5, 8'h00, "rd ch1"};
        tbl[5]  = '{1'b1, 8'h10, 8'h77, 32'h3C0000A5, 8'h00, "wr unmapped"};
        tbl[6]  = '{1'b0, 8'h10, 8'h00, 32'h3C0000A5, 8'h00, "rd unmapped"};
        tbl[7]  = '{1'b0, 8'hFC, 8'h00, 32'h3C0000A5, 8'h00, "rd push reg"};
        tbl[8]  = '{1'b0, 8'hFD, 8'h00, 32'h3C0000A5, 8'h20, "rd status idle"};
        tbl[9]  = '{1'b1, 8'hFA, 8'h5A, 32'h3C5A00A5, 8'h00, "wr ch2"};
        tbl[10] = '{1'b0, 8'hFA, 8'h00, 32'h3C5A00A5, 8'h5A, "rd ch2"};

        rst = 1'b0;
        #3;
        chk("reset ch_out", ch_out_o, 0);
        chk("reset rd_data", rd_data_o, 0);
        chk("reset rd_valid", rd_valid_o, 0);
        chk("reset strm_valid", strm_valid_o, 0);
        chk("reset strm_data", strm_data_o, 0);
        chk("reset overflow", overflow_o, 0);
        #4 rst = 1'b1;
        tick();
        mon_en = 1'b1;

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].is_wr) begin
                wr(tbl[i].addr, tbl[i].data);
                chk(tbl[i].name, ch_out_o, tbl[i].exp_ch);
            end else begin
                rd(tbl[i].addr, tbl[i].exp_rd, tbl[i].name);
                chk({tbl[i].name, " ch_out"}, ch_out_o, tbl[i].exp_ch);
            end
        end

        // Read and write of the same register in one cycle returns the old value.
        addr_i = 8'hF8; wr_data_i = 8'h11; we_i = 1'b1; re_i = 1'b1;
        tick();
        we_i = 1'b0; re_i = 1'b0;
        chk("rd-during-wr old value", rd_data_o, 8'hA5);
        chk("rd-during-wr ch_out", ch_out_o, 32'h3C5A0011);

        // Fill past depth with consumer stalled.
        for (int i = 1; i <= 5; i++) push(8'(i));
        rd(8'hFD, 8'hC4, "status full+ovf");
        drain("fill");
        rd(8'hFD, 8'hA0, "status empty+ovf");

        // Clearing overflow through the status register.
        wr(8'hFD, 8'h00);
        chk("ovf cleared", overflow_o, 0);

        // Push into a full FIFO during a pop is accepted.
        for (int i = 1; i <= 4; i++) push(8'(i + 8'h20));
        strm_ready_i = 1'b1;
        push(8'h09);
        strm_ready_i = 1'b0;
        rd(8'hFD, 8'h44, "status full push+pop");
        drain("push+pop");
        chk("no ovf after push+pop", overflow_o, 0);

        // Asynchronous reset mid-transfer.
        for (int i = 1; i <= 3; i++) push(8'(i + 8'h30));
        #2;
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst ch_out", ch_out_o, 0);
        chk("midrst strm_valid", strm_valid_o, 0);
        chk("midrst strm_data", strm_data_o, 0);
        chk("midrst overflow", overflow_o, 0);
        chk("midrst rd_valid", rd_valid_o, 0);
        q.delete();
        exp_ovf = 1'b0;
        #3 rst = 1'b1;
        tick();
        mon_en = 1'b1;
        chk("post-rst strm_valid", strm_valid_o, 0);
        rd(8'hFD, 8'h20, "status after reset");

        // Sustained push and pop across pointer wrap.
        strm_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) push(8'(i + 8'h40));
        drain("stream");
        chk("stream overflow", overflow_o, 0);
        rd(8'hFD, 8'h20, "status after stream");

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
